// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared widths, halt opcode and FSM encoding for the instruction memory port
package inst_mem_pkg;
    localparam int AW = 11;
    localparam int DW = 9;
    localparam int DEPTH = 2 ** AW;
    localparam logic [DW-1:0] HALT_OP = '1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;
endpackage

// File: rtl/inst_mem_array.sv
// inst_mem_array: 1W/1R synchronous RAM, unreset storage, registered read port
module inst_mem_array
    import inst_mem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [DEPTH];

    // storage write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // read register only updates on a fetch so it holds across LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd <= '0;
        else if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/inst_mem_port.sv
// inst_mem_port: program loader and 1-cycle-latency instruction fetch responder
module inst_mem_port
    import inst_mem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] prog_ctr,
    output logic [DW-1:0] instr_out,
    output logic          instr_valid,
    output logic          fetch_oob,
    output logic          halt,
    input  logic          load_en,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic [AW:0]   load_count,
    output logic          load_full
);
    state_t state, next;
    logic [DW-1:0] rd;
    logic we, fetch, in_bounds;

    // next-state and handshake decode
    always_comb begin
        next = state;
        case (state)
            EMPTY:   next = load_en ? LOAD : EMPTY;
            LOAD:    next = load_en ? LOAD : (load_count != '0 ? RUN : EMPTY);
            RUN:     next = load_en ? LOAD : RUN;
            default: next = EMPTY;
        endcase
        load_full  = load_count == DEPTH_CNT;
        load_ready = state == LOAD && load_en && !load_full;
        we         = load_valid && load_ready;
        fetch      = state == RUN && !load_en;
        in_bounds  = {1'b0, prog_ctr} < load_count;
    end

    // state, write counter (doubles as write pointer) and fetch status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            load_count  <= '0;
            instr_valid <= 1'b0;
            fetch_oob   <= 1'b0;
        end else begin
            state       <= next;
            instr_valid <= fetch;
            if (next == LOAD && state != LOAD) load_count <= '0;
            else if (we) load_count <= load_count + 1'b1;
            if (fetch) fetch_oob <= !in_bounds;
        end
    end

    inst_mem_array u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wa    (load_count[AW-1:0]),
        .wd    (load_data),
        .re    (fetch && in_bounds),
        .ra    (prog_ctr),
        .rd    (rd)
    );

    assign instr_out = fetch_oob ? HALT_OP : rd;
    assign halt      = instr_valid && instr_out == HALT_OP;
endmodule
